// File: rtl/vc_plane_slot_mux_pkg.sv
// Shared constants and helpers for the VC plane slot multiplexer.
package vc_plane_slot_mux_pkg;

  localparam int VC_DEFAULT         = 4;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int STAT_WIDTH         = 16;

  // Bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/vc_plane_slot_mux_fifo.sv
// Single-plane synchronous FIFO with occupancy count; pushes when full and
// pops when empty are ignored.
import vc_plane_slot_mux_pkg::*;

module vc_plane_fifo #(
  parameter  int WIDTH = DATA_WIDTH_DEFAULT,
  parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Power-of-two depth lets the pointers wrap without compare logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vc_plane_slot_mux.sv
// Drains per-VC flit FIFOs onto one shared channel, one plane per cycle as
// named by the external selector. Optional idle-slot counters: VC_PLANE_STATS_EN.
import vc_plane_slot_mux_pkg::*;

module vc_plane_slot_mux #(
  parameter int VC         = VC_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VC:0]              vc_plane_selector,
  input  logic [VC*DATA_WIDTH-1:0] in_data,
  input  logic [VC-1:0]            in_valid,
  output logic [VC-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [VC:0]              out_vc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_error
`ifdef VC_PLANE_STATS_EN
  ,
  output logic [VC*STAT_WIDTH-1:0] idle_slots
`endif
);

  localparam int SEL_W = VC + 1;
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] head [VC];
  logic [CNT_W-1:0]      cnt  [VC];
  logic [VC-1:0]         full, empty, push, pop;

  logic                  load, sel_ok, sel_empty, do_pop;
  logic [DATA_WIDTH-1:0] sel_head;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [VC:0]           out_vc_q, out_vc_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sel_error_q, sel_error_d;

  for (genvar i = 0; i < VC; i++) begin : g_fifo
    // in_ready is forced low while reset is held.
    assign in_ready[i] = rst & (cnt[i] != CNT_W'(FIFO_DEPTH));
    assign push[i]     = in_valid[i] & ~full[i];

    vc_plane_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop       (pop[i]),
      .head      (head[i]),
      .count     (cnt[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  // A stalled output register swallows the slot: no pop, selector ignored.
  always_comb begin
    load      = out_ready | ~out_valid_q;
    sel_ok    = (vc_plane_selector < SEL_W'(VC));
    sel_empty = 1'b1;
    sel_head  = '0;
    for (int i = 0; i < VC; i++) begin
      if (vc_plane_selector == SEL_W'(i)) begin
        sel_empty = empty[i];
        sel_head  = head[i];
      end
    end
    do_pop = load & sel_ok & ~sel_empty;
    pop    = '0;
    for (int i = 0; i < VC; i++) begin
      pop[i] = do_pop & (vc_plane_selector == SEL_W'(i));
    end
    out_valid_d = load ? do_pop : out_valid_q;
    out_data_d  = do_pop ? sel_head : out_data_q;
    out_vc_d    = do_pop ? vc_plane_selector : out_vc_q;
    sel_error_d = ~sel_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_vc_q    <= '0;
      out_valid_q <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_vc_q    <= out_vc_d;
      out_valid_q <= out_valid_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_vc    = out_vc_q;
  assign out_valid = out_valid_q;
  assign sel_error = sel_error_q;

`ifdef VC_PLANE_STATS_EN
  logic [STAT_WIDTH-1:0] idle_q [VC];
  logic [STAT_WIDTH-1:0] idle_d [VC];

  // A wasted slot: this plane owned an accepting cycle but had nothing queued.
  always_comb begin
    for (int i = 0; i < VC; i++) begin
      idle_d[i] = idle_q[i];
      if (load && (vc_plane_selector == SEL_W'(i)) && empty[i] && (idle_q[i] != '1))
        idle_d[i] = idle_q[i] + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VC; i++) idle_q[i] <= '0;
    end else begin
      for (int i = 0; i < VC; i++) idle_q[i] <= idle_d[i];
    end
  end

  for (genvar i = 0; i < VC; i++) begin : g_stat
    assign idle_slots[i*STAT_WIDTH +: STAT_WIDTH] = idle_q[i];
  end
`endif

endmodule

// File: tb/tb_vc_plane_slot_mux.sv
// Bench for vc_plane_slot_mux: directed sequences, a vector table and random
// traffic, all checked against a queue-based reference model.
module tb_vc_plane_slot_mux;

  localparam int VC    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst;
  logic [VC:0]       sel;
  logic [VC*DW-1:0]  in_data;
  logic [VC-1:0]     in_valid;
  logic [VC-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic [VC:0]       out_vc;
  logic              out_valid;
  logic              out_ready;
  logic              sel_error;
`ifdef VC_PLANE_STATS_EN
  logic [VC*16-1:0]  idle_slots;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vc_plane_slot_mux #(.VC(VC), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .vc_plane_selector (sel),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_vc            (out_vc),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .sel_error         (sel_error)
`ifdef VC_PLANE_STATS_EN
    ,
    .idle_slots        (idle_slots)
`endif
  );

  // ---------------- reference model ----------------
  logic [DW-1:0]    mq [VC][$];
  logic             m_valid;
  logic [DW-1:0]    m_data;
  logic [VC:0]      m_vc;
  logic             m_err;
  int               m_idle [VC];
  logic [VC+DW:0]   exp_q [$];

  int n_vec;
  int n_err;

  typedef struct {
    logic [VC:0]   sel;
    logic          exp_valid;
    logic [VC:0]   exp_vc;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < VC; i++) begin
      mq[i].delete();
      m_idle[i] = 0;
    end
    m_valid = 1'b0;
    m_data  = '0;
    m_vc    = '0;
    m_err   = 1'b0;
    exp_q.delete();
  endtask

  // One clock: model predicts from the current inputs, then DUT is compared.
  task automatic step();
    int            p;
    bit            ld;
    bit [VC-1:0]   acc;
    logic [VC-1:0] er;
    logic [VC+DW:0] e;
    p  = int'(sel);
    ld = out_ready || !m_valid;
    for (int i = 0; i < VC; i++) acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
    if (p < VC && ld && mq[p].size() == 0 && m_idle[p] < 65535) m_idle[p]++;
    if (ld) begin
      if (p < VC && mq[p].size() > 0) begin
        m_data  = mq[p].pop_front();
        m_vc    = (VC+1)'(p);
        m_valid = 1'b1;
        exp_q.push_back({m_vc, m_data});
      end else begin
        m_valid = 1'b0;
      end
    end
    m_err = (p >= VC);
    for (int i = 0; i < VC; i++) if (acc[i]) mq[i].push_back(in_data[i*DW +: DW]);

    @(posedge clk);
    #1;
    for (int i = 0; i < VC; i++) er[i] = (mq[i].size() != DEPTH);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_vc",    64'(out_vc),    64'(m_vc));
    chk("sel_error", 64'(sel_error), 64'(m_err));
    chk("in_ready",  64'(in_ready),  64'(er));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("flit", 64'({out_vc, out_data}), 64'(e));
    end
`ifdef VC_PLANE_STATS_EN
    for (int i = 0; i < VC; i++) chk("idle_slots", 64'(idle_slots[i*16 +: 16]), 64'(m_idle[i]));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    model_clear();

    tbl[0]  = '{5'd0, 1'b1, 5'd0, 32'hB000_0000};
    tbl[1]  = '{5'd0, 1'b1, 5'd0, 32'hB000_0001};
    tbl[2]  = '{5'd0, 1'b0, 5'd0, 32'hB000_0001};
    tbl[3]  = '{5'd1, 1'b1, 5'd1, 32'hB000_0010};
    tbl[4]  = '{5'd2, 1'b1, 5'd2, 32'hB000_0020};
    tbl[5]  = '{5'd3, 1'b1, 5'd3, 32'hB000_0030};
    tbl[6]  = '{5'd0, 1'b0, 5'd3, 32'hB000_0030};
    tbl[7]  = '{5'd0, 1'b0, 5'd3, 32'hB000_0030};
    tbl[8]  = '{5'd0, 1'b0, 5'd3, 32'hB000_0030};
    tbl[9]  = '{5'd1, 1'b1, 5'd1, 32'hB000_0011};
    tbl[10] = '{5'd2, 1'b1, 5'd2, 32'hB000_0021};
    tbl[11] = '{5'd3, 1'b1, 5'd3, 32'hB000_0031};

    // Reset state
    #2 rst = 1'b0;
    #10;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_vc",    64'(out_vc),    64'd0);
    chk("rst_sel_error", 64'(sel_error), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single flit on VC1: visible two clocks after it is presented
    sel = 5'd1; in_valid = 4'b0010; in_data[1*DW +: DW] = 32'hA0;
    step();
    chk("lat_valid_c1", 64'(out_valid), 64'd0);
    in_valid = '0;
    step();
    chk("lat_valid_c2", 64'(out_valid), 64'd1);
    chk("lat_data_c2",  64'(out_data),  64'hA0);
    chk("lat_vc_c2",    64'(out_vc),    64'd1);
    chk("lat_ready",    64'(in_ready),  64'hF);

    // Fill VC0 past full while its plane is never selected
    sel = 5'd1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'b0001;
      in_data[0 +: DW] = 32'hC0 + k;
      step();
      chk("full_ready0", 64'(in_ready[0]), (k >= 3) ? 64'd0 : 64'd1);
    end
    sel = 5'd0;
    step();
    chk("pop_when_full_data", 64'(out_data), 64'hC0);
    chk("ready0_after_pop",   64'(in_ready[0]), 64'd1);
    sel = 5'd1;
    step();
    chk("refill_ready0", 64'(in_ready[0]), 64'd0);
    in_valid = '0;
    sel = 5'd0;
    for (int k = 0; k < 5; k++) step();

    // Two flits per VC, then the table-driven selector pattern
    sel = 5'd4;
    for (int k = 0; k < 2; k++) begin
      in_valid = 4'hF;
      for (int i = 0; i < VC; i++) in_data[i*DW +: DW] = 32'hB000_0000 | (i << 4) | k;
      step();
    end
    in_valid = '0;
    for (int j = 0; j < 12; j++) begin
      sel = tbl[j].sel;
      step();
      chk("tbl_valid", 64'(out_valid), 64'(tbl[j].exp_valid));
      chk("tbl_vc",    64'(out_vc),    64'(tbl[j].exp_vc));
      chk("tbl_data",  64'(out_data),  64'(tbl[j].exp_data));
    end

    // Output stall: slots lost while the selector keeps cycling
    sel = 5'd4;
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b0001;
      in_data[0 +: DW] = 32'hD0 + k;
      step();
    end
    in_valid = '0;
    sel = 5'd0;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = (VC+1)'(k);
      step();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data",  64'(out_data),  64'hD0);
      chk("stall_vc",    64'(out_vc),    64'd0);
    end
    out_ready = 1'b1;
    sel = 5'd0;
    step();
    chk("release_data", 64'(out_data), 64'hD1);
    sel = 5'd1;
    step();
    sel = 5'd0;
    step();
    chk("release_data2", 64'(out_data), 64'hD2);

    // Out-of-range selector
    sel = 5'd5;
    step();
    chk("sel_err_hi", 64'(sel_error), 64'd1);
    sel = 5'd1;
    step();
    chk("sel_err_lo", 64'(sel_error), 64'd0);

    // Reset in the middle of traffic
    sel = 5'd4;
    in_valid = 4'hF;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < VC; i++) in_data[i*DW +: DW] = 32'hE000_0000 | (i << 4) | k;
      step();
    end
    in_valid = '0;
    sel = 5'd0;
    step();
    rst = 1'b0;
    #2;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
`ifdef VC_PLANE_STATS_EN
    chk("mid_rst_idle",  64'(idle_slots), 64'd0);
`endif
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    sel = 5'd1;
    step();
    chk("flushed_vc1", 64'(out_valid), 64'd0);

    // Idle-slot accounting on an empty plane
    sel = 5'd2;
    for (int k = 0; k < 10; k++) step();
`ifdef VC_PLANE_STATS_EN
    chk("idle_vc2_10", 64'(idle_slots[2*16 +: 16]), 64'd10);
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = VC'($urandom);
      for (int i = 0; i < VC; i++) in_data[i*DW +: DW] = $urandom;
      sel       = (VC+1)'($urandom_range(0, 5));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
